// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and control bundles for the pipeline controller.
// Optional jump support is selected by the PIPE_CTRL_JUMP_EN macro (see ctrl_decode).
package pipeline_ctrl_pkg;

  // Primary opcodes (InstrD[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (InstrD[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] ALUSRC_REG = 2'b00;
  localparam logic [1:0] ALUSRC_IMM = 2'b01;

  // Next-PC select
  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full decoded control bundle (decode stage and E stage)
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       reg_dst;
    logic [1:0] alu_src;
    logic [2:0] alu_control;
  } ctrl_t;

  // Controls still needed once the instruction has left E
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic branch;
  } m_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } w_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main decoder: Opcode/Funct -> control bundle, jump flag, illegal flag.
// With PIPE_CTRL_JUMP_EN defined, opcode j raises jump_o; otherwise j is illegal.
module ctrl_decode
  import pipeline_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o,
  output logic       jump_o,
  output logic       illegal_o
);

  // Decode; anything unrecognised collapses to an all-zero nop with illegal_o set
  always_comb begin
    ctrl_o    = '0;
    jump_o    = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_src   = ALUSRC_REG;
        case (funct_i)
          FN_ADD:  ctrl_o.alu_control = ALU_ADD;
          FN_SUB:  ctrl_o.alu_control = ALU_SUB;
          FN_AND:  ctrl_o.alu_control = ALU_AND;
          FN_OR:   ctrl_o.alu_control = ALU_OR;
          FN_SLT:  ctrl_o.alu_control = ALU_SLT;
          default: begin
            ctrl_o    = '0;
            illegal_o = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.mem_to_reg  = 1'b1;
        ctrl_o.alu_src     = ALUSRC_IMM;
        ctrl_o.alu_control = ALU_ADD;
      end
      OP_SW: begin
        ctrl_o.mem_write   = 1'b1;
        ctrl_o.alu_src     = ALUSRC_IMM;
        ctrl_o.alu_control = ALU_ADD;
      end
      OP_ADDI: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.alu_src     = ALUSRC_IMM;
        ctrl_o.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch      = 1'b1;
        ctrl_o.alu_control = ALU_SUB;
      end
`ifdef PIPE_CTRL_JUMP_EN
      // Jump resolves in D; it writes nothing into the pipeline
      OP_J: begin
        jump_o = 1'b1;
      end
`endif
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipelined control unit: decode in D, control registers for E, M and W,
// next-PC select. Jump support is enabled by defining PIPE_CTRL_JUMP_EN.
module pipeline_controller
  import pipeline_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       FlushE,
  input  logic       ZeroM,
  output logic       RegDstE,
  output logic [1:0] ALUSrcE,
  output logic [2:0] ALUControlE,
  output logic       RegWriteE,
  output logic       MemToRegE,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       RegWriteW,
  output logic       MemToRegW,
  output logic [1:0] PCSrc,
  output logic       IllegalD
);

  ctrl_t   ctrl_d;
  logic    jump_d;
  ctrl_t   e_d, e_q;
  m_ctrl_t m_d, m_q;
  w_ctrl_t w_d, w_q;

  ctrl_decode u_decode (
    .opcode_i  (Opcode),
    .funct_i   (Funct),
    .ctrl_o    (ctrl_d),
    .jump_o    (jump_d),
    .illegal_o (IllegalD)
  );

  // Next-stage values; a flush inserts a bubble into E only, M and W keep flowing
  always_comb begin
    e_d = FlushE ? '0 : ctrl_d;
    m_d = '{reg_write:  e_q.reg_write,
            mem_to_reg: e_q.mem_to_reg,
            mem_write:  e_q.mem_write,
            branch:     e_q.branch};
    w_d = '{reg_write:  m_q.reg_write,
            mem_to_reg: m_q.mem_to_reg};
  end

  // Pipeline control registers; reset wins over flush and clears every stage
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Next-PC select; a taken branch in M is older than a jump in D, so it wins
  always_comb begin
    PCSrc = PCSRC_PLUS4;
    if (m_q.branch && ZeroM) begin
      PCSrc = PCSRC_BRANCH;
    end else if (jump_d) begin
      PCSrc = PCSRC_JUMP;
    end
  end

  assign RegDstE     = e_q.reg_dst;
  assign ALUSrcE     = e_q.alu_src;
  assign ALUControlE = e_q.alu_control;
  assign RegWriteE   = e_q.reg_write;
  assign MemToRegE   = e_q.mem_to_reg;
  assign RegWriteM   = m_q.reg_write;
  assign MemWriteM   = m_q.mem_write;
  assign RegWriteW   = w_q.reg_write;
  assign MemToRegW   = w_q.mem_to_reg;

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Opcode  input  6  InstrD[31:26] from datapath decode stage.
REQ-005 Funct  input  6  InstrD[5:0] from datapath decode stage.
REQ-006 FlushE  input  1  hazard-unit request to bubble the E stage on next edge.
REQ-007 ZeroM  input  1  registered ALU zero flag, M stage.
REQ-008 RegDstE  output  1  0 = rt, 1 = rd write-register select.
REQ-009 ALUSrcE  output  2  00 = register B, 01 = SignImmE; 10/11 never driven.
REQ-010 ALUControlE  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-011 RegWriteE, MemToRegE  output  1 each  E-stage copies for hazard detection.
REQ-012 RegWriteM, MemWriteM  output  1 each  M-stage controls.
REQ-013 RegWriteW, MemToRegW  output  1 each  W-stage controls.
REQ-014 PCSrc  output  2  00 PC+4, 01 branch target, 10 jump target.
REQ-015 IllegalD  output  1  combinational; Opcode/Funct not recognised.

Function
REQ-016 Decode combinational from Opcode/Funct: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-017 R-type: RegWrite=1, RegDst=1, ALUSrc=00, ALUControl from Funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt).
REQ-018 lw: RegWrite=1, MemToReg=1, ALUSrc=01, add; sw: MemWrite=1, ALUSrc=01, add; addi: RegWrite=1, ALUSrc=01, add; beq: Branch=1, sub.
REQ-019 Unknown opcode or unknown R-type Funct: all decoded controls 0 (nop), IllegalD=1 same cycle.
REQ-020 D->E register captures decoded controls each edge; E->M, M->W registers advance each edge; latency D->E 1, D->M 2, D->W 3 cycles.
REQ-021 FlushE=1: E register loads all-zero controls (bubble); M and W still advance.
REQ-022 PCSrc=01 when BranchM & ZeroM; BranchM & !ZeroM gives 00.
REQ-023 PCSrc=10 combinationally in D when Opcode=j; j writes no pipeline control.
REQ-024 Simultaneous jump in D and taken branch in M: PCSrc=01 (older instruction wins).
REQ-025 Only signals listed in REQ-008..015 are exported; BranchE/BranchM internal.

Reset
REQ-026 reset=1 on an edge zeroes all E/M/W control registers; reset has priority over FlushE.
REQ-027 After reset every registered output is 0; PCSrc=00 unless Opcode=j in D.
REQ-028 Reset mid-stream discards all in-flight controls; no write enable asserts until a new instruction reaches that stage.

Configuration
REQ-029 Macro PIPE_CTRL_JUMP_EN defined: j decoded per REQ-023.
REQ-030 Macro PIPE_CTRL_JUMP_EN undefined: opcode 000010 illegal (IllegalD=1, nop), PCSrc never 10.

Structure
REQ-031 Package pipeline_ctrl_pkg holds opcode, funct, ALUControl and PCSrc encoding constants.
REQ-032 One combinational sub-module ctrl_decode (Opcode, Funct -> decoded control bundle, IllegalD); pipeline registers stay in pipeline_controller.

Verification
REQ-033 reset held 2 cycles, Opcode=100011 -> all registered outputs 0 during reset; MemToRegE=1 one cycle after release, RegWriteW=1 & MemToRegW=1 three cycles after.
REQ-034 Opcode=000000, Funct=101010 -> next edge ALUControlE=111, RegDstE=1, ALUSrcE=00, RegWriteE=1.
REQ-035 beq (000100) then ZeroM=1 two cycles later -> PCSrc=01 that cycle; repeat with ZeroM=0 -> PCSrc=00.
REQ-036 sw decoded with FlushE=1 at capture edge -> MemWriteM stays 0 next cycle; prior instruction in E still reaches M.
REQ-037 Opcode=111111 -> IllegalD=1, all stage controls 0 through W.
REQ-038 j with PIPE_CTRL_JUMP_EN defined -> PCSrc=10 same cycle; undefined -> IllegalD=1, PCSrc=00.
